// File: rtl/tlul_sram_responder.sv
// tlul_sram_responder
//   TL-UL device-side responder. Terminates a TL-UL A/D channel pair and
//   drives a req/gnt/rvalid single-port memory. Illegal A requests are
//   answered locally with d_error and never reach the memory. Up to
//   Outstanding accepted requests may be in flight; D responses come back
//   strictly in acceptance order.
//
// Ports
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   tl_i          : A channel + d_ready (tl_h2d_t)
//   tl_o          : D channel + a_ready (tl_d2h_t)
//   req_o/gnt_i   : memory request handshake (transfer on req_o && gnt_i)
//   we_o          : write enable
//   addr_o        : word address, a_address[AddrWidth+1:2]
//   wdata_o       : write data
//   wmask_o       : bit-level write mask (a_mask expanded per byte)
//   rdata_i       : read data, qualified by rvalid_i
//   rvalid_i      : one pulse per granted read, in grant order

package tlul_sram_pkg;

    localparam logic [2:0] OpPutFull       = 3'h0;
    localparam logic [2:0] OpPutPartial    = 3'h1;
    localparam logic [2:0] OpGet           = 3'h4;
    localparam logic [2:0] OpAccessAck     = 3'h0;
    localparam logic [2:0] OpAccessAckData = 3'h1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic [15:0] a_user;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic [0:0]  d_sink;
        logic [31:0] d_data;
        logic [15:0] d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

    typedef struct packed {
        logic       is_read;
        logic       error;
        logic [1:0] size;
        logic [7:0] source;
    } trk_entry_t;

endpackage

module tlul_sram_responder
    import tlul_sram_pkg::*;
#(
    parameter int Outstanding = 2,
    parameter int AddrWidth   = 15
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  tl_h2d_t              tl_i,
    output tl_d2h_t              tl_o,
    output logic                 req_o,
    input  logic                 gnt_i,
    output logic                 we_o,
    output logic [AddrWidth-1:0] addr_o,
    output logic [31:0]          wdata_o,
    output logic [31:0]          wmask_o,
    input  logic [31:0]          rdata_i,
    input  logic                 rvalid_i
);

    localparam int PtrW = (Outstanding > 1) ? $clog2(Outstanding) : 1;
    localparam int CntW = $clog2(Outstanding + 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(Outstanding);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(Outstanding - 1);

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrLast) ? '0 : p + PtrW'(1);
    endfunction

    // ------------------------------------------------------------------
    // Legality check (combinational on the A channel)
    // ------------------------------------------------------------------
    logic [3:0] addr_bytes;   // bytes covered by a_address/a_size
    logic       misaligned;
    logic       op_ok, size_ok, mask_outside, full_short, illegal, a_err;

    always_comb begin
        addr_bytes = 4'b0000;
        misaligned = 1'b0;
        case (tl_i.a_size)
            2'd0: addr_bytes = 4'b0001 << tl_i.a_address[1:0];
            2'd1: begin
                addr_bytes = tl_i.a_address[1] ? 4'b1100 : 4'b0011;
                misaligned = tl_i.a_address[0];
            end
            2'd2: begin
                addr_bytes = 4'b1111;
                misaligned = |tl_i.a_address[1:0];
            end
            default: ;
        endcase
    end

    assign op_ok        = (tl_i.a_opcode == OpGet) || (tl_i.a_opcode == OpPutFull) ||
                          (tl_i.a_opcode == OpPutPartial);
    assign size_ok      = (tl_i.a_size <= 2'd2);
    assign mask_outside = |(tl_i.a_mask & ~addr_bytes);
    assign full_short   = (tl_i.a_opcode == OpPutFull) && (tl_i.a_mask != addr_bytes);
    assign illegal      = !op_ok || !size_ok || misaligned || mask_outside || full_short;
    // Qualified by a_valid so idle bus contents never make a_ready rise.
    assign a_err        = tl_i.a_valid && illegal;

    // ------------------------------------------------------------------
    // Tracking FIFO
    // ------------------------------------------------------------------
    trk_entry_t            trk_mem [Outstanding];
    logic [PtrW-1:0]       trk_wptr, trk_rptr;
    logic [CntW-1:0]       trk_cnt;
    logic                  trk_full, trk_empty, trk_push, trk_pop;
    trk_entry_t            trk_in, trk_head;

    // ------------------------------------------------------------------
    // Read-data FIFO
    // ------------------------------------------------------------------
    logic [31:0]           rd_mem [Outstanding];
    logic [PtrW-1:0]       rd_wptr, rd_rptr;
    logic [CntW-1:0]       rd_cnt;
    logic [CntW-1:0]       rd_pend;     // granted reads awaiting rvalid_i
    logic                  rd_push, rd_pop, rd_empty, mem_rd_gnt;

    logic                  a_ready, d_valid, head_rd_ok;

    assign trk_full  = (trk_cnt == CntMax);
    assign trk_empty = (trk_cnt == '0);
    assign rd_empty  = (rd_cnt == '0);
    assign trk_head  = trk_mem[trk_rptr];

    // Memory side
    assign req_o   = tl_i.a_valid && !illegal && !trk_full;
    assign we_o    = (tl_i.a_opcode == OpPutFull) || (tl_i.a_opcode == OpPutPartial);
    assign addr_o  = tl_i.a_address[AddrWidth+1:2];
    assign wdata_o = tl_i.a_data;
    always_comb begin
        wmask_o = '0;
        for (int b = 0; b < 4; b++) wmask_o[b*8 +: 8] = {8{tl_i.a_mask[b]}};
    end

    assign a_ready    = !trk_full && (a_err || gnt_i);
    assign trk_push   = tl_i.a_valid && a_ready;
    assign mem_rd_gnt = req_o && gnt_i && !we_o;

    assign trk_in.is_read = (tl_i.a_opcode == OpGet);
    assign trk_in.error   = illegal;
    assign trk_in.size    = tl_i.a_size;
    assign trk_in.source  = tl_i.a_source;

    // Reads with no outstanding grant are protocol violations and dropped.
    assign rd_push    = rvalid_i && (rd_pend != '0);
    assign head_rd_ok = trk_head.is_read && !trk_head.error;
    assign d_valid    = !trk_empty && (!head_rd_ok || !rd_empty);
    assign trk_pop    = d_valid && tl_i.d_ready;
    assign rd_pop     = trk_pop && head_rd_ok;

    // Control state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            trk_wptr <= '0;
            trk_rptr <= '0;
            trk_cnt  <= '0;
            rd_wptr  <= '0;
            rd_rptr  <= '0;
            rd_cnt   <= '0;
            rd_pend  <= '0;
        end else begin
            if (trk_push) trk_wptr <= ptr_inc(trk_wptr);
            if (trk_pop)  trk_rptr <= ptr_inc(trk_rptr);
            case ({trk_push, trk_pop})
                2'b10:   trk_cnt <= trk_cnt + CntW'(1);
                2'b01:   trk_cnt <= trk_cnt - CntW'(1);
                default: ;
            endcase

            if (rd_push) rd_wptr <= ptr_inc(rd_wptr);
            if (rd_pop)  rd_rptr <= ptr_inc(rd_rptr);
            case ({rd_push, rd_pop})
                2'b10:   rd_cnt <= rd_cnt + CntW'(1);
                2'b01:   rd_cnt <= rd_cnt - CntW'(1);
                default: ;
            endcase

            case ({mem_rd_gnt, rd_push})
                2'b10:   rd_pend <= rd_pend + CntW'(1);
                2'b01:   rd_pend <= rd_pend - CntW'(1);
                default: ;
            endcase
        end
    end

    // Storage needs no reset: occupancy counters gate every read of it.
    always_ff @(posedge clk_i) begin
        if (trk_push) trk_mem[trk_wptr] <= trk_in;
        if (rd_push)  rd_mem[rd_wptr]   <= rdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && rvalid_i) begin
            assert (rd_pend != '0)
            else $warning("rvalid_i with no pending read dropped");
        end
    end

    // ------------------------------------------------------------------
    // D channel
    // ------------------------------------------------------------------
    always_comb begin
        tl_o          = '0;
        tl_o.a_ready  = a_ready;
        tl_o.d_valid  = d_valid;
        tl_o.d_opcode = trk_head.is_read ? OpAccessAckData : OpAccessAck;
        tl_o.d_size   = trk_head.size;
        tl_o.d_source = trk_head.source;
        tl_o.d_error  = trk_head.error;
        if (head_rd_ok)                               tl_o.d_data = rd_mem[rd_rptr];
        else if (trk_head.is_read && trk_head.error)  tl_o.d_data = '1;
        else                                          tl_o.d_data = '0;
    end

    logic unused_tl;
    assign unused_tl = ^{tl_i.a_param, tl_i.a_user, tl_i.a_address};

endmodule

// File: tb/tb_tlul_sram_responder.sv
// Directed bench for tlul_sram_responder (Outstanding=2, AddrWidth=15).
// Inputs change 1 ns after the rising edge; outputs are checked 2 ns after it.
module tb_tlul_sram_responder;
    import tlul_sram_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    tl_h2d_t     tl_i;
    tl_d2h_t     tl_o;
    logic        req_o, gnt_i, we_o, rvalid_i;
    logic [14:0] addr_o;
    logic [31:0] wdata_o, wmask_o, rdata_i;

    int total = 0;
    int bad   = 0;

    tlul_sram_responder #(.Outstanding(2), .AddrWidth(15)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .tl_i(tl_i), .tl_o(tl_o),
        .req_o(req_o), .gnt_i(gnt_i), .we_o(we_o), .addr_o(addr_o),
        .wdata_o(wdata_o), .wmask_o(wmask_o), .rdata_i(rdata_i), .rvalid_i(rvalid_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_a(input logic [2:0] op, input logic [1:0] sz, input logic [31:0] addr,
                           input logic [3:0] mask, input logic [31:0] data, input logic [7:0] src);
        tl_i.a_valid   = 1'b1;
        tl_i.a_opcode  = op;
        tl_i.a_size    = sz;
        tl_i.a_address = addr;
        tl_i.a_mask    = mask;
        tl_i.a_data    = data;
        tl_i.a_source  = src;
    endtask

    task automatic idle_a();
        tl_i.a_valid = 1'b0;
    endtask

    initial begin
        tl_i     = '0;
        tl_i.d_ready = 1'b1;
        gnt_i    = 1'b0;
        rvalid_i = 1'b0;
        rdata_i  = '0;
        rst_ni   = 1'b0;

        // ---------------- reset state ----------------
        #1;
        chk("rst_d_valid", tl_o.d_valid, 0);
        chk("rst_req", req_o, 0);
        chk("rst_a_ready_gnt0", tl_o.a_ready, 0);
        gnt_i = 1'b1; #1;
        chk("rst_a_ready_gnt1", tl_o.a_ready, 1);
        gnt_i = 1'b0;
        repeat (2) cyc();
        rst_ni = 1'b1;
        cyc();

        // ---------------- full write ----------------
        drive_a(OpPutFull, 2, 32'h10, 4'hF, 32'hDEADBEEF, 8'd5);
        gnt_i = 1'b1; #1;
        chk("wr_req", req_o, 1);
        chk("wr_we", we_o, 1);
        chk("wr_addr", addr_o, 4);
        chk("wr_wmask", wmask_o, 32'hFFFFFFFF);
        chk("wr_wdata", wdata_o, 32'hDEADBEEF);
        chk("wr_a_ready", tl_o.a_ready, 1);
        chk("wr_no_early_d", tl_o.d_valid, 0);
        cyc();
        idle_a(); gnt_i = 1'b0; #1;
        chk("wr_d_valid", tl_o.d_valid, 1);
        chk("wr_d_opcode", tl_o.d_opcode, OpAccessAck);
        chk("wr_d_error", tl_o.d_error, 0);
        chk("wr_d_source", tl_o.d_source, 5);
        chk("wr_d_size", tl_o.d_size, 2);
        chk("wr_d_data", tl_o.d_data, 0);
        chk("wr_d_user", tl_o.d_user, 0);
        cyc(); #1;
        chk("wr_popped", tl_o.d_valid, 0);

        // ---------------- read ----------------
        drive_a(OpGet, 2, 32'h10, 4'hF, 32'h0, 8'd6);
        gnt_i = 1'b1; #1;
        chk("rd_req", req_o, 1);
        chk("rd_we", we_o, 0);
        cyc();
        idle_a(); gnt_i = 1'b0;
        rvalid_i = 1'b1; rdata_i = 32'hDEADBEEF; #1;
        chk("rd_wait_rvalid", tl_o.d_valid, 0);
        cyc();
        rvalid_i = 1'b0; rdata_i = '0; #1;
        chk("rd_d_valid", tl_o.d_valid, 1);
        chk("rd_d_opcode", tl_o.d_opcode, OpAccessAckData);
        chk("rd_d_data", tl_o.d_data, 32'hDEADBEEF);
        chk("rd_d_source", tl_o.d_source, 6);
        chk("rd_d_error", tl_o.d_error, 0);
        cyc(); #1;
        chk("rd_popped", tl_o.d_valid, 0);

        // ---------------- errors ----------------
        drive_a(OpGet, 3, 32'h0, 4'hF, 32'h0, 8'd7); #1;
        chk("esz_req", req_o, 0);
        chk("esz_a_ready", tl_o.a_ready, 1);
        cyc(); idle_a(); #1;
        chk("esz_d_valid", tl_o.d_valid, 1);
        chk("esz_d_opcode", tl_o.d_opcode, OpAccessAckData);
        chk("esz_d_error", tl_o.d_error, 1);
        chk("esz_d_data", tl_o.d_data, 32'hFFFFFFFF);
        cyc();

        drive_a(OpPutFull, 2, 32'h2, 4'hF, 32'h1, 8'd8); #1;
        chk("emis_req", req_o, 0);
        cyc(); idle_a(); #1;
        chk("emis_d_opcode", tl_o.d_opcode, OpAccessAck);
        chk("emis_d_error", tl_o.d_error, 1);
        chk("emis_d_data", tl_o.d_data, 0);
        cyc();

        drive_a(3'h7, 2, 32'h0, 4'hF, 32'h0, 8'd9); #1;
        chk("eop_req", req_o, 0);
        cyc(); idle_a(); #1;
        chk("eop_d_valid", tl_o.d_valid, 1);
        chk("eop_d_opcode", tl_o.d_opcode, OpAccessAck);
        chk("eop_d_error", tl_o.d_error, 1);
        cyc();

        // ---------------- partial write ----------------
        drive_a(OpPutPartial, 0, 32'h1, 4'h2, 32'h0000AB00, 8'd10);
        gnt_i = 1'b1; #1;
        chk("pp_req", req_o, 1);
        chk("pp_wmask", wmask_o, 32'h0000FF00);
        cyc(); idle_a(); gnt_i = 1'b0; #1;
        chk("pp_d_opcode", tl_o.d_opcode, OpAccessAck);
        chk("pp_d_error", tl_o.d_error, 0);
        cyc();
        drive_a(OpPutPartial, 0, 32'h1, 4'h4, 32'h0, 8'd10);
        gnt_i = 1'b1; #1;
        chk("ppbad_req", req_o, 0);
        cyc(); idle_a(); gnt_i = 1'b0; #1;
        chk("ppbad_d_error", tl_o.d_error, 1);
        cyc();

        // ---------------- backpressure and ordering ----------------
        tl_i.d_ready = 1'b0;
        drive_a(OpGet, 2, 32'h20, 4'hF, 32'h0, 8'd1);
        gnt_i = 1'b1; #1;
        chk("bp_rd_a_ready", tl_o.a_ready, 1);
        cyc();
        drive_a(OpGet, 3, 32'h0, 4'hF, 32'h0, 8'd2);
        gnt_i = 1'b0;
        rvalid_i = 1'b1; rdata_i = 32'h12345678; #1;
        chk("bp_err_a_ready", tl_o.a_ready, 1);
        chk("bp_err_req", req_o, 0);
        cyc();
        rvalid_i = 1'b0; rdata_i = '0;
        drive_a(OpPutFull, 2, 32'h24, 4'hF, 32'hA5A5A5A5, 8'd3);
        gnt_i = 1'b1; #1;
        chk("bp_full_a_ready", tl_o.a_ready, 0);
        chk("bp_full_req", req_o, 0);
        chk("bp_head_valid", tl_o.d_valid, 1);
        chk("bp_head_src", tl_o.d_source, 1);
        cyc(); #1;
        chk("bp_hold_valid", tl_o.d_valid, 1);
        chk("bp_hold_src", tl_o.d_source, 1);
        chk("bp_hold_data", tl_o.d_data, 32'h12345678);
        chk("bp_hold_a_ready", tl_o.a_ready, 0);
        tl_i.d_ready = 1'b1;
        cyc(); #1;
        chk("ord2_src", tl_o.d_source, 2);
        chk("ord2_error", tl_o.d_error, 1);
        chk("ord2_data", tl_o.d_data, 32'hFFFFFFFF);
        chk("ord2_a_ready", tl_o.a_ready, 1);
        cyc();
        idle_a(); gnt_i = 1'b0; #1;
        chk("ord3_valid", tl_o.d_valid, 1);
        chk("ord3_src", tl_o.d_source, 3);
        chk("ord3_opcode", tl_o.d_opcode, OpAccessAck);
        chk("ord3_error", tl_o.d_error, 0);
        cyc(); #1;
        chk("ord_drained", tl_o.d_valid, 0);

        // ---------------- reset mid-flight ----------------
        drive_a(OpGet, 2, 32'h40, 4'hF, 32'h0, 8'd11);
        gnt_i = 1'b1;
        cyc();
        drive_a(OpGet, 2, 32'h44, 4'hF, 32'h0, 8'd12);
        cyc();
        idle_a(); #1;
        chk("mf_full_a_ready", tl_o.a_ready, 0);
        chk("mf_pending_no_d", tl_o.d_valid, 0);
        rst_ni = 1'b0; #1;
        chk("mf_rst_d_valid", tl_o.d_valid, 0);
        chk("mf_rst_a_ready", tl_o.a_ready, 1);
        gnt_i = 1'b0; #1;
        chk("mf_rst_a_ready_gnt0", tl_o.a_ready, 0);
        cyc();
        rst_ni = 1'b1;
        cyc();
        rvalid_i = 1'b1; rdata_i = 32'hBAD0BAD0;
        cyc();
        rvalid_i = 1'b0; rdata_i = '0; #1;
        chk("mf_stale_dropped", tl_o.d_valid, 0);
        drive_a(OpPutFull, 2, 32'h0, 4'hF, 32'h55, 8'd13);
        gnt_i = 1'b1;
        cyc();
        idle_a(); gnt_i = 1'b0; #1;
        chk("mf_fresh_valid", tl_o.d_valid, 1);
        chk("mf_fresh_src", tl_o.d_source, 13);
        chk("mf_fresh_opcode", tl_o.d_opcode, OpAccessAck);
        cyc(); #1;
        chk("mf_fresh_popped", tl_o.d_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
